// File: rtl/iqdemap_16qam.sv
`default_nettype none
// ============================================================================
//  Module   : iqdemap_16qam
//  Brief    : Hard-decision 16QAM demapper with 128-bit word packer and a
//             one-word output register behind a valid/busy writer handshake.
//             Define IQDEMAP_16QAM_THR_EN to add a runtime `thr` port.
//  Revision : 1.0 - initial release
// ============================================================================
module iqdemap_16qam #(
  parameter int WIDTH = 10,
  parameter int UNIT  = 64
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ce,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] i_data,
  input  logic [WIDTH-1:0] q_data,
`ifdef IQDEMAP_16QAM_THR_EN
  input  logic [WIDTH-2:0] thr,
`endif
  input  logic             flush,
  output logic [127:0]     writer_data,
  output logic             writer_en,
  input  logic             writer_busy,
  output logic             ovf,
  output logic [4:0]       sym_cnt
);

  localparam logic [WIDTH:0] c_one = (WIDTH+1)'(1);

  logic [127:0] r_pack;
  logic [4:0]   r_sym_cnt;
  logic [127:0] r_writer_data;
  logic         r_writer_en;
  logic         r_ovf;

  logic [WIDTH:0] w_i_ext, w_q_ext, w_i_abs, w_q_abs, w_thr;
  logic [3:0]     w_nibble;
  logic           w_accept, w_complete, w_flush_emit, w_emit, w_xfer;
  logic [5:0]     w_cnt_after;
  logic [7:0]     w_shift;
  logic [127:0]   w_pack_next, w_word;

`ifdef IQDEMAP_16QAM_THR_EN
  assign w_thr = {2'b00, thr};
`else
  assign w_thr = (WIDTH+1)'(2 * UNIT);
`endif

  // One extra bit keeps |most-negative| representable.
  assign w_i_ext = {i_data[WIDTH-1], i_data};
  assign w_q_ext = {q_data[WIDTH-1], q_data};
  assign w_i_abs = i_data[WIDTH-1] ? (~w_i_ext + c_one) : w_i_ext;
  assign w_q_abs = q_data[WIDTH-1] ? (~w_q_ext + c_one) : w_q_ext;

  assign w_nibble = {i_data[WIDTH-1], q_data[WIDTH-1],
                     (w_i_abs < w_thr), (w_q_abs < w_thr)};

  assign w_accept    = ce & valid_i;
  assign w_pack_next = w_accept ? {r_pack[123:0], w_nibble} : r_pack;
  assign w_cnt_after = {1'b0, r_sym_cnt} + {5'b00000, w_accept};
  assign w_complete  = (w_cnt_after == 6'd32);
  assign w_flush_emit = ce & flush & ~w_complete & (w_cnt_after != 6'd0);
  assign w_emit      = w_complete | w_flush_emit;
  assign w_xfer      = r_writer_en & ~writer_busy;

  // Left-align a partial word; a full word has a zero shift.
  assign w_shift = {6'd32 - w_cnt_after, 2'b00};
  assign w_word  = w_pack_next << w_shift;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pack        <= '0;
      r_sym_cnt     <= '0;
      r_writer_data <= '0;
      r_writer_en   <= 1'b0;
      r_ovf         <= 1'b0;
    end else if (ce) begin
      r_pack    <= w_emit ? '0 : w_pack_next;
      r_sym_cnt <= w_emit ? 5'd0 : w_cnt_after[4:0];
      if (w_emit && (!r_writer_en || w_xfer)) begin
        r_writer_data <= w_word;
        r_writer_en   <= 1'b1;
      end else begin
        if (w_emit) begin
          r_ovf <= 1'b1;
        end
        if (w_xfer) begin
          r_writer_en <= 1'b0;
        end
      end
    end
  end

  assign writer_data = r_writer_data;
  assign writer_en   = r_writer_en;
  assign ovf         = r_ovf;
  assign sym_cnt     = r_sym_cnt;

endmodule
`default_nettype wire

// File: tb/tb_iqdemap_16qam.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iqdemap_16qam
//  Brief    : Directed self-checking bench for iqdemap_16qam (default build).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_iqdemap_16qam;

  logic         CLK = 1'b0;
  logic         RST, ce, valid_i, flush, writer_busy;
  logic [9:0]   i_data, q_data;
  logic [127:0] writer_data;
  logic         writer_en, ovf;
  logic [4:0]   sym_cnt;

  iqdemap_16qam #(.WIDTH(10), .UNIT(64)) dut (
    .CLK(CLK), .RST(RST), .ce(ce), .valid_i(valid_i),
    .i_data(i_data), .q_data(q_data), .flush(flush),
    .writer_data(writer_data), .writer_en(writer_en),
    .writer_busy(writer_busy), .ovf(ovf), .sym_cnt(sym_cnt)
  );

  always #5 CLK = ~CLK;

  int           checks = 0;
  int           errors = 0;
  logic [127:0] exp_q[$];
  logic [127:0] m_word = '0;
  int           m_cnt = 0;
  bit           m_full = 0;
  bit           exp_ovf = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_nib(input int i, input int q);
    int ai, aq;
    ai = (i < 0) ? -i : i;
    aq = (q < 0) ? -q : q;
    return {(i < 0), (q < 0), (ai < 128), (aq < 128)};
  endfunction

  task automatic model_emit();
    if (m_full) exp_ovf = 1;
    else begin
      exp_q.push_back(m_word);
      m_full = 1;
    end
    m_word = '0;
    m_cnt  = 0;
  endtask

  task automatic step(input bit v, input int i, input int q, input bit f);
    valid_i = v;
    i_data  = i[9:0];
    q_data  = q[9:0];
    flush   = f;
    @(posedge CLK); #1;
    valid_i = 0;
    flush   = 0;
    if (ce) begin
      if (v) begin
        m_word[127-4*m_cnt -: 4] = model_nib(i, q);
        m_cnt++;
        if (m_cnt == 32) model_emit();
      end
      if (f && m_cnt > 0) model_emit();
    end
  endtask

  function automatic int rnd();
    return int'($urandom_range(0, 1023)) - 512;
  endfunction

  // Writer side: a transfer happens at the next rising edge.
  always @(negedge CLK) begin
    if (!RST && ce && writer_en && !writer_busy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_word: observed=%0h expected=none", writer_data);
      end else begin
        check("word", writer_data, exp_q.pop_front());
      end
      m_full = 0;
    end
  end

  initial begin
    RST = 1; ce = 1; valid_i = 0; flush = 0; writer_busy = 0;
    i_data = '0; q_data = '0;
    #12;
    check("rst_en", 128'(writer_en), 128'd0);
    check("rst_data", writer_data, 128'd0);
    check("rst_ovf", 128'(ovf), 128'd0);
    check("rst_cnt", 128'(sym_cnt), 128'd0);
    @(posedge CLK); #1;
    RST = 0;

    // Alternating pattern gives A5 repeated
    for (int k = 0; k < 32; k++)
      step(1, (k % 2) ? 192 : -64, (k % 2) ? -64 : 192, 0);
    check("alt_en", 128'(writer_en), 128'd1);
    check("alt_data", writer_data, {16{8'hA5}});
    check("alt_ovf", 128'(ovf), 128'd0);
    step(0, 0, 0, 0);
    check("alt_en_clr", 128'(writer_en), 128'd0);

    // Slicer boundaries, then flush
    step(1, 0, 0, 0);
    step(1, -128, 128, 0);
    step(1, -512, -512, 0);
    step(0, 0, 0, 1);
    check("bnd_data", writer_data, 128'h38C << 116);
    check("bnd_cnt", 128'(sym_cnt), 128'd0);
    step(0, 0, 0, 0);

    step(1, 192, 192, 0);
    step(1, -192, -192, 0);
    step(1, 64, 64, 0);
    step(0, 0, 0, 1);
    check("flush_data", writer_data, 128'h0C3 << 116);
    check("flush_cnt", 128'(sym_cnt), 128'd0);
    step(0, 0, 0, 0);

    // Flush with empty packer does nothing
    step(0, 0, 0, 1);
    check("flush0_en", 128'(writer_en), 128'd0);
    check("flush0_cnt", 128'(sym_cnt), 128'd0);

    // Flush coinciding with the 32nd symbol yields one word only
    for (int k = 0; k < 31; k++) step(1, rnd(), rnd(), 0);
    step(1, rnd(), rnd(), 1);
    check("fv_en", 128'(writer_en), 128'd1);
    check("fv_cnt", 128'(sym_cnt), 128'd0);
    step(0, 0, 0, 0);
    check("fv_en_clr", 128'(writer_en), 128'd0);

    // Writer stalled across two words
    writer_busy = 1;
    for (int k = 0; k < 64; k++) step(1, rnd(), rnd(), 0);
    check("busy_en", 128'(writer_en), 128'd1);
    check("busy_ovf", 128'(ovf), 128'(exp_ovf));
    check("busy_data", writer_data, exp_q[0]);
    writer_busy = 0;
    step(0, 0, 0, 0);
    check("busy_en_clr", 128'(writer_en), 128'd0);

    // Clock-enable gaps with junk inputs between symbols
    for (int k = 0; k < 32; k++) begin
      ce = 0;
      step(1, rnd(), rnd(), 1);
      check("ce_freeze_cnt", 128'(sym_cnt), 128'(m_cnt[4:0]));
      ce = 1;
      step(1, rnd(), rnd(), 0);
    end
    check("ce_en", 128'(writer_en), 128'd1);
    step(0, 0, 0, 0);

    // Asynchronous reset mid-word
    for (int k = 0; k < 10; k++) step(1, rnd(), rnd(), 0);
    #2 RST = 1;
    #1;
    check("arst_cnt", 128'(sym_cnt), 128'd0);
    check("arst_en", 128'(writer_en), 128'd0);
    check("arst_data", writer_data, 128'd0);
    check("arst_ovf", 128'(ovf), 128'd0);
    m_word = '0; m_cnt = 0; m_full = 0; exp_ovf = 0;
    exp_q.delete();
    @(posedge CLK); #1;
    RST = 0;
    for (int k = 0; k < 32; k++) step(1, rnd(), rnd(), 0);
    check("post_rst_en", 128'(writer_en), 128'd1);
    step(0, 0, 0, 0);

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) step(0, 0, 0, 0);
    check("queue_drained", 128'(exp_q.size()), 128'd0);
    check("final_ovf", 128'(ovf), 128'(exp_ovf));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/iqdemap_16qam.md
# iqdemap_16qam

Hard-decision 16QAM demapper and 128-bit word packer: the receive-side counterpart of `iqmap_16qam`. It takes one signed I/Q sample per accepted cycle and slices it to 4 bits (ISDB-T Gray mapping). It packs 32 symbols MSB-first into a 128-bit word and hands each word to a downstream writer through a valid/busy handshake. A one-word output register decouples symbol intake from writer stalls.

## Interface
- `WIDTH`, 10: signed I/Q sample width.
- `UNIT`, 64: nominal inner constellation amplitude. Levels are ±UNIT and ±3·UNIT.
- `CLK`  in  1: clock, rising edge.
- `RST`  in  1: reset, asynchronous, active-high.
- `ce`  in  1: clock enable. When low, all state freezes and inputs are ignored. Output registers hold their values.
- `valid_i`  in  1: `i_data`/`q_data` hold a symbol. Sampled only when `ce`=1.
- `i_data`  in  WIDTH: signed in-phase sample.
- `q_data`  in  WIDTH: signed quadrature sample.
- `flush`  in  1: single-cycle request to emit a partial word. Sampled when `ce`=1.
- `writer_data`  out  128: packed word.
- `writer_en`  out  1: `writer_data` is valid. Held until accepted.
- `writer_busy`  in  1: a transfer occurs on any cycle with `writer_en`=1 and `writer_busy`=0.
- `ovf`  out  1: sticky overflow flag. Cleared only by `RST`.
- `sym_cnt`  out  5: number of symbols currently in the packing register.

## Operation
- Slicing per symbol produces bits y0..y3. Use (WIDTH+1)-bit absolute values so the most negative input does not overflow.
  - y0 = (I<0). I=0 gives y0=0.
  - y1 = (Q<0).
  - y2 = (|I| < THR).
  - y3 = (|Q| < THR). |x| = THR gives 0 (outer ring).
  - THR = 2·UNIT.
  - Nibble order is {y0,y1,y2,y3}, with y0 at the nibble MSB.
- Packing:
  - The shift register `pack[127:0]` is left-shifted by 4 with the new nibble in bits [3:0]. The first symbol of a word therefore ends in bits [127:124].
  - `sym_cnt` counts 0..31 and wraps to 0 when the 32nd symbol is accepted. The word is then complete.
- Output register and handshake:
  - A complete word moves into `writer_data` and sets `writer_en`, provided the output register is empty or is being emptied in the same cycle (`writer_en`=1 and `writer_busy`=0).
  - If a word completes while the output register is full and not transferring, the new word is dropped and `ovf` is set. Packing continues with `sym_cnt`=0.
  - `writer_en` clears on transfer unless a new word loads in the same cycle. In that case it stays 1 with the new data.
- Flush:
  - With `sym_cnt`=k>0, the partial word is left-aligned (packed nibbles in the top 4k bits, zeros below). It follows the same load/overflow rule, and `sym_cnt` goes to 0.
  - `flush` with `sym_cnt`=0 and no symbol in the same cycle has no effect.
  - `flush` together with `valid_i` in the same cycle includes that symbol first, then flushes. If that symbol completes the word, the result is one normal word only.
- Reset: `writer_data`=0, `writer_en`=0, `ovf`=0, `sym_cnt`=0, `pack`=0. `RST` asserted mid-word discards the partial word.

## Timing
- The 32nd symbol is accepted at rising edge N. `writer_en`=1 with the word is visible after edge N; the writer can take it at edge N+1. Latency is 1 cycle.
- Throughput: one symbol per `ce` cycle with no bubbles. The writer has 32 `ce` cycles per word to accept before overflow.
- All outputs are registered. There are no combinational paths from input to output.

## Configuration
- `IQDEMAP_16QAM_THR_EN` defined: adds input port `thr` (WIDTH-1 bits, unsigned), sampled every accepted symbol, and THR = `thr`. This supports AGC-tracked thresholds.
- `IQDEMAP_16QAM_THR_EN` undefined: no `thr` port, and THR is the constant 2·UNIT.

## Test plan
All scenarios use defaults (WIDTH=10, UNIT=64, THR=128) unless stated.
- Alternate (I=-64,Q=+192) and (I=+192,Q=-64) for 32 symbols, `writer_busy`=0 -> one `writer_en` pulse one cycle after the 32nd symbol, `writer_data`=128'hA5A5…A5 (16 bytes of A5), `ovf`=0.
- Boundaries: I=0,Q=0 -> nibble 4'b0011. I=-128,Q=128 -> 4'b1000. I=-512,Q=-512 -> 4'b1100.
- `flush` after 3 symbols of (+192,+192), (-192,-192), (+64,+64) -> `writer_data`=128'h0C3 followed by 29 zero nibbles (128'h0C30…0), `sym_cnt`=0.
- `writer_busy` held 1 across two complete words -> first word held with `writer_en`=1, second dropped, `ovf`=1. Release busy -> first word transfers, `writer_en`=0.
- `ce` toggled 1/0 during a word -> same word value as the ungated run. State is frozen while `ce`=0.
- `RST` pulsed mid-word after 10 symbols -> all outputs 0 at once (asynchronous). The next 32 symbols form a clean word.
